// File: rtl/regfile_port_arbiter.sv
// Round-robin arbiter sharing the register file's single read and write port among NREQ requesters,
// with owner locking for atomic read-modify-write sequences and registered register-file controls.
module regfile_port_arbiter #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_write,
  input  logic [NREQ-1:0]          req_lock,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic [ADDR_W-1:0]        rf_read_addr,
  input  logic [DATA_W-1:0]        rf_read_data,
  output logic                     rf_wr_enable,
  output logic [ADDR_W-1:0]        rf_wr_addr,
  output logic [DATA_W-1:0]        rf_wr_data
);

  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {ARB, LOCKED} state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W-1:0]  owner_q, owner_d;
  logic [PTR_W-1:0]  gnt_idx;
  logic              found;
  logic [NREQ-1:0]   grant;
  logic              accept;
  logic              sel_write;
  logic              sel_lock;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [NREQ-1:0]   rd_pend_q;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] idx);
    if (idx == PTR_W'(NREQ - 1)) return '0;
    return idx + PTR_W'(1);
  endfunction

  // Grant selection: rotate from the pointer in ARB, owner only in LOCKED; nothing while in reset.
  always_comb begin
    int unsigned idx;
    idx     = 0;
    found   = 1'b0;
    gnt_idx = '0;
    grant   = '0;
    if (state_q == ARB) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        idx = 32'(ptr_q) + k;
        if (idx >= NREQ) idx = idx - NREQ;
        if (!found && req_valid[PTR_W'(idx)]) begin
          found   = 1'b1;
          gnt_idx = PTR_W'(idx);
        end
      end
    end else if (req_valid[owner_q]) begin
      found   = 1'b1;
      gnt_idx = owner_q;
    end
    if (found && rst_n) grant[gnt_idx] = 1'b1;
  end

  assign req_ready = grant;
  assign accept    = |grant;

  // Payload of the granted requester.
  always_comb begin
    sel_write = 1'b0;
    sel_lock  = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_write = req_write[i];
        sel_lock  = req_lock[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  // Lock ownership persists until the owner completes a request with req_lock low.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    case (state_q)
      ARB: begin
        if (accept) begin
          ptr_d = next_ptr(gnt_idx);
          if (sel_lock) begin
            state_d = LOCKED;
            owner_d = gnt_idx;
          end
        end
      end
      LOCKED: begin
        if (accept && !sel_lock) begin
          state_d = ARB;
          ptr_d   = next_ptr(owner_q);
        end
      end
      default: state_d = ARB;
    endcase
  end

  // Two-stage read pipe (address, then data capture) and single-stage write pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_q    <= '0;
      rsp_valid    <= '0;
      rsp_rdata    <= '0;
      rf_read_addr <= '0;
      rf_wr_enable <= 1'b0;
      rf_wr_addr   <= '0;
      rf_wr_data   <= '0;
    end else begin
      rd_pend_q    <= (accept && !sel_write) ? grant : '0;
      rsp_valid    <= rd_pend_q;
      rf_wr_enable <= accept && sel_write;
      if (accept && !sel_write) rf_read_addr <= sel_addr;
      if (|rd_pend_q)           rsp_rdata    <= rf_read_data;
      if (accept && sel_write) begin
        rf_wr_addr <= sel_addr;
        rf_wr_data <= sel_wdata;
      end
    end
  end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter: per-cycle vector table plus hand-written lock and reset
// sequences, with a behavioural 32x32 register file attached to the read/write ports.
module tb_regfile_port_arbiter;

  localparam int unsigned NREQ   = 4;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;

  logic                    clk;
  logic                    rst_n;
  logic [NREQ-1:0]         req_valid, req_write, req_lock;
  logic [NREQ*ADDR_W-1:0]  req_addr;
  logic [NREQ*DATA_W-1:0]  req_wdata;
  logic [NREQ-1:0]         req_ready, rsp_valid;
  logic [DATA_W-1:0]       rsp_rdata;
  logic [ADDR_W-1:0]       rf_read_addr;
  logic [DATA_W-1:0]       rf_read_data;
  logic                    rf_wr_enable;
  logic [ADDR_W-1:0]       rf_wr_addr;
  logic [DATA_W-1:0]       rf_wr_data;

  logic                    rf_init;
  logic [DATA_W-1:0]       regs [32];

  int n_cmp = 0;
  int n_err = 0;

  regfile_port_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_write(req_write), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rf_read_addr(rf_read_addr), .rf_read_data(rf_read_data),
    .rf_wr_enable(rf_wr_enable), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file: register a holds 0xA000_0000|a until written.
  always @(posedge clk) begin
    if (rf_init) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'hA000_0000 | 32'(i);
    end else if (rf_wr_enable) begin
      regs[rf_wr_addr] <= rf_wr_data;
    end
  end
  assign rf_read_data = regs[rf_read_addr];

  typedef struct {
    logic [3:0]  valid, write, lock;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  exp_ready, exp_rsp;
    logic [31:0] exp_rdata;
    logic        exp_wen;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs [19];

  function automatic vec_t mk(input logic [3:0] v, w, l, input logic [4:0] a, input logic [31:0] d,
                              input logic [3:0] rdy, rsp, input logic [31:0] rd,
                              input logic wen, input logic [4:0] wa, input logic [31:0] wd);
    vec_t r;
    r.valid = v; r.write = w; r.lock = l; r.addr = a; r.wdata = d;
    r.exp_ready = rdy; r.exp_rsp = rsp; r.exp_rdata = rd;
    r.exp_wen = wen; r.exp_waddr = wa; r.exp_wdata = wd;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // All requesters present the same address and write data; the grant decides who is served.
  task automatic drive(input logic [3:0] v, w, l, input logic [4:0] a, input logic [31:0] d);
    req_valid = v;
    req_write = w;
    req_lock  = l;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*ADDR_W +: ADDR_W]  = a;
      req_wdata[i*DATA_W +: DATA_W] = d;
    end
  endtask

  task automatic step(input logic [3:0] v, w, l, input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    drive(v, w, l, a, d);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " ready"},     32'(req_ready),    32'h0);
    chk({tag, " rsp_valid"}, 32'(rsp_valid),    32'h0);
    chk({tag, " rsp_rdata"}, rsp_rdata,         32'h0);
    chk({tag, " rd_addr"},   32'(rf_read_addr), 32'h0);
    chk({tag, " wr_en"},     32'(rf_wr_enable), 32'h0);
    chk({tag, " wr_addr"},   32'(rf_wr_addr),   32'h0);
    chk({tag, " wr_data"},   rf_wr_data,        32'h0);
  endtask

  initial begin
    rst_n   = 1'b0;
    rf_init = 1'b1;
    drive(4'h0, 4'h0, 4'h0, 5'd0, 32'h0);

    // Round-robin reads, boundary writes (addr 31 / addr 0), lock with release, write-then-read ordering.
    vecs[0]  = mk(4'hF, 4'h0, 4'h0, 5'd4,  32'h0,         4'h1, 4'h0, 32'h0,         1'b0, 5'd0,  32'h0);
    vecs[1]  = mk(4'hF, 4'h0, 4'h0, 5'd5,  32'h0,         4'h2, 4'h0, 32'h0,         1'b0, 5'd0,  32'h0);
    vecs[2]  = mk(4'hF, 4'h0, 4'h0, 5'd6,  32'h0,         4'h4, 4'h1, 32'hA000_0004, 1'b0, 5'd0,  32'h0);
    vecs[3]  = mk(4'hF, 4'h0, 4'h0, 5'd7,  32'h0,         4'h8, 4'h2, 32'hA000_0005, 1'b0, 5'd0,  32'h0);
    vecs[4]  = mk(4'hF, 4'h0, 4'h0, 5'd8,  32'h0,         4'h1, 4'h4, 32'hA000_0006, 1'b0, 5'd0,  32'h0);
    vecs[5]  = mk(4'h0, 4'h0, 4'h0, 5'd0,  32'h0,         4'h0, 4'h8, 32'hA000_0007, 1'b0, 5'd0,  32'h0);
    vecs[6]  = mk(4'h0, 4'h0, 4'h0, 5'd0,  32'h0,         4'h0, 4'h1, 32'hA000_0008, 1'b0, 5'd0,  32'h0);
    vecs[7]  = mk(4'h2, 4'h2, 4'h0, 5'd31, 32'h1,         4'h2, 4'h0, 32'h0,         1'b0, 5'd0,  32'h0);
    vecs[8]  = mk(4'h4, 4'h4, 4'h0, 5'd0,  32'hFFFF_FFFF, 4'h4, 4'h0, 32'h0,         1'b1, 5'd31, 32'h1);
    vecs[9]  = mk(4'h0, 4'h0, 4'h0, 5'd0,  32'h0,         4'h0, 4'h0, 32'h0,         1'b1, 5'd0,  32'hFFFF_FFFF);
    vecs[10] = mk(4'h0, 4'h0, 4'h0, 5'd0,  32'h0,         4'h0, 4'h0, 32'h0,         1'b0, 5'd0,  32'h0);
    vecs[11] = mk(4'h4, 4'h0, 4'h4, 5'd9,  32'h0,         4'h4, 4'h0, 32'h0,         1'b0, 5'd0,  32'h0);
    vecs[12] = mk(4'hD, 4'h0, 4'h4, 5'd10, 32'h0,         4'h4, 4'h0, 32'h0,         1'b0, 5'd0,  32'h0);
    vecs[13] = mk(4'hD, 4'h4, 4'h0, 5'd12, 32'h1234_5678, 4'h4, 4'h4, 32'hA000_0009, 1'b0, 5'd0,  32'h0);
    vecs[14] = mk(4'h9, 4'h0, 4'h0, 5'd12, 32'h0,         4'h8, 4'h4, 32'hA000_000A, 1'b1, 5'd12, 32'h1234_5678);
    vecs[15] = mk(4'h9, 4'h0, 4'h0, 5'd12, 32'h0,         4'h1, 4'h0, 32'h0,         1'b0, 5'd0,  32'h0);
    vecs[16] = mk(4'h0, 4'h0, 4'h0, 5'd0,  32'h0,         4'h0, 4'h8, 32'h1234_5678, 1'b0, 5'd0,  32'h0);
    vecs[17] = mk(4'h0, 4'h0, 4'h0, 5'd0,  32'h0,         4'h0, 4'h1, 32'h1234_5678, 1'b0, 5'd0,  32'h0);
    vecs[18] = mk(4'h0, 4'h0, 4'h0, 5'd0,  32'h0,         4'h0, 4'h0, 32'h0,         1'b0, 5'd0,  32'h0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk_all_zero("reset");
    rf_init = 1'b0;
    rst_n   = 1'b1;

    for (int i = 0; i < 19; i++) begin
      step(vecs[i].valid, vecs[i].write, vecs[i].lock, vecs[i].addr, vecs[i].wdata);
      chk($sformatf("r%0d ready", i),     32'(req_ready),    32'(vecs[i].exp_ready));
      chk($sformatf("r%0d rsp_valid", i), 32'(rsp_valid),    32'(vecs[i].exp_rsp));
      chk($sformatf("r%0d wr_en", i),     32'(rf_wr_enable), 32'(vecs[i].exp_wen));
      if (vecs[i].exp_rsp != 4'h0) chk($sformatf("r%0d rsp_rdata", i), rsp_rdata, vecs[i].exp_rdata);
      if (vecs[i].exp_wen) begin
        chk($sformatf("r%0d wr_addr", i), 32'(rf_wr_addr), 32'(vecs[i].exp_waddr));
        chk($sformatf("r%0d wr_data", i), rf_wr_data,       vecs[i].exp_wdata);
      end
    end

    // Write then read of the same register by requester 1 on back-to-back cycles.
    step(4'h2, 4'h2, 4'h0, 5'd5, 32'hDEAD_BEEF);
    chk("wr5 ready", 32'(req_ready), 32'h2);
    step(4'h2, 4'h0, 4'h0, 5'd5, 32'h0);
    chk("rd5 ready", 32'(req_ready), 32'h2);
    chk("wr5 wr_en", 32'(rf_wr_enable), 32'h1);
    chk("wr5 wr_addr", 32'(rf_wr_addr), 32'd5);
    chk("wr5 wr_data", rf_wr_data, 32'hDEAD_BEEF);
    step(4'h0, 4'h0, 4'h0, 5'd0, 32'h0);
    chk("rd5 t+2 rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rd5 t+2 wr_en", 32'(rf_wr_enable), 32'h0);
    step(4'h0, 4'h0, 4'h0, 5'd0, 32'h0);
    chk("rd5 rsp_valid", 32'(rsp_valid), 32'h2);
    chk("rd5 rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
    step(4'h0, 4'h0, 4'h0, 5'd0, 32'h0);
    chk("rd5 rsp end", 32'(rsp_valid), 32'h0);

    // Owner 0 takes the lock, then idles while everyone else waits.
    step(4'h1, 4'h0, 4'h1, 5'd2, 32'h0);
    chk("lock0 ready", 32'(req_ready), 32'h1);
    for (int i = 0; i < 5; i++) begin
      step(4'hE, 4'h0, 4'h0, 5'd2, 32'h0);
      chk($sformatf("lock0 idle%0d ready", i), 32'(req_ready), 32'h0);
    end
    step(4'hF, 4'h0, 4'h0, 5'd2, 32'h0);
    chk("lock0 release ready", 32'(req_ready), 32'h1);
    step(4'hF, 4'h0, 4'h0, 5'd2, 32'h0);
    chk("after release ready", 32'(req_ready), 32'h2);
    step(4'h0, 4'h0, 4'h0, 5'd0, 32'h0);
    step(4'h0, 4'h0, 4'h0, 5'd0, 32'h0);

    // Reset while a locked read is in flight and a write is being presented.
    step(4'h4, 4'h0, 4'h4, 5'd3, 32'h0);
    chk("pre-rst read ready", 32'(req_ready), 32'h4);
    step(4'h4, 4'h4, 4'h4, 5'd3, 32'h55);
    chk("pre-rst write ready", 32'(req_ready), 32'h4);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    step(4'hF, 4'h0, 4'h0, 5'd0, 32'h0);
    chk("in-rst ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'hF, 4'h0, 4'h0, 5'd1, 32'h0);
    #1;
    chk("post-rst ready", 32'(req_ready), 32'h1);
    chk("post-rst rsp_valid", 32'(rsp_valid), 32'h0);
    chk("post-rst wr_en", 32'(rf_wr_enable), 32'h0);
    step(4'h0, 4'h0, 4'h0, 5'd0, 32'h0);
    chk("post-rst+1 rsp_valid", 32'(rsp_valid), 32'h0);
    chk("post-rst+1 wr_en", 32'(rf_wr_enable), 32'h0);
    step(4'h0, 4'h0, 4'h0, 5'd0, 32'h0);
    chk("post-rst+2 rsp_valid", 32'(rsp_valid), 32'h1);
    chk("post-rst+2 rsp_rdata", rsp_rdata, 32'hA000_0001);
    chk("post-rst+2 wr_en", 32'(rf_wr_enable), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
